spi_master_frame: RTL and testbench

- FPGA-side SPI master that runs one full-duplex frame of FRAME_BITS bits per request.
- Drives sck, cs_n and sdo; samples sdi.
- Pairs with the team's SPI slave receiver: mode 0 (CPOL=0, CPHA=0), MSB first, slave shifts in on sck rising edge and updates its output on sck falling edge.
- Used to push coefficients/commands and read back 10-bit samples in 32-bit frames.

---
 rtl/spi_master_frame.sv | 144 ++++++++++++++
 tb/tb_spi_master_frame.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_frame.sv
// spi_master_frame: SPI mode-0 master that runs one full-duplex frame of
// FRAME_BITS bits per accepted start request.
//
// Optional feature: define SPI_LSB_FIRST_EN to shift LSB first on both sdo
// and sdi (rx_data stays LSB-first ordered). Timing is identical either way.
//
// Handshake: start is a request, accepted only on a clk edge where the FSM is
// IDLE; busy is high from the cycle after acceptance until the DONE cycle, and
// start seen in any other state (including DONE) is dropped, not queued.
// done is a one-cycle pulse in the DONE cycle, and rx_data is valid from that
// cycle on.
module spi_master_frame #(
    parameter int FRAME_BITS = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sck,
    output logic                  cs_n,
    output logic                  sdo,
    input  logic                  sdi
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_ALL  = BW'(FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [HW-1:0]         hcnt, hcnt_next;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] tx_sr, rx_sr;
    logic [FRAME_BITS-1:0] tx_shifted, rx_shifted;
    logic                  half_end;
    logic                  accept;
    logic                  enter_high;
    logic                  high_to_low;

    assign half_end    = (hcnt == H_LAST);
    assign accept      = (state == S_IDLE) && start;
    assign enter_high  = (state_next == S_HIGH) && (state != S_HIGH);
    assign high_to_low = (state == S_HIGH) && (state_next == S_LOW);

    // sdo comes straight off the end of the tx shift register, so it is a
    // flop output and simply holds once the shifting stops.
`ifdef SPI_LSB_FIRST_EN
    assign tx_shifted = {1'b0, tx_sr[FRAME_BITS-1:1]};
    assign rx_shifted = {sdi, rx_sr[FRAME_BITS-1:1]};
    assign sdo        = tx_sr[0];
`else
    assign tx_shifted = {tx_sr[FRAME_BITS-2:0], 1'b0};
    assign rx_shifted = {rx_sr[FRAME_BITS-2:0], sdi};
    assign sdo        = tx_sr[FRAME_BITS-1];
`endif

    // State and half-period counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            hcnt  <= '0;
        end else begin
            state <= state_next;
            hcnt  <= hcnt_next;
        end
    end

    // Next-state logic: every non-idle phase except DONE lasts CLK_DIV cycles.
    always_comb begin
        state_next = state;
        hcnt_next  = '0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_SETUP;
            end
            S_SETUP, S_HIGH, S_LOW: begin
                hcnt_next = half_end ? '0 : hcnt + 1'b1;
                if (half_end) begin
                    if (state == S_SETUP)      state_next = S_HIGH;
                    else if (state == S_HIGH)  state_next = S_LOW;
                    else if (bit_cnt < B_ALL)  state_next = S_HIGH;
                    else                       state_next = S_DONE;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered pin/status outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck  <= 1'b0;
            cs_n <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            sck  <= (state_next == S_HIGH);
            cs_n <= (state_next == S_IDLE) || (state_next == S_DONE);
            busy <= (state_next == S_SETUP) || (state_next == S_HIGH) ||
                    (state_next == S_LOW);
            done <= (state_next == S_DONE);
        end
    end

    // Shift datapath: capture on accept, sample sdi on sck rise, advance sdo
    // on sck fall while bits remain, publish rx_data on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) begin
                tx_sr   <= tx_data;
                bit_cnt <= '0;
            end
            if (enter_high) begin
                rx_sr   <= rx_shifted;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (high_to_low && (bit_cnt < B_ALL)) begin
                tx_sr <= tx_shifted;
            end
            if (state_next == S_DONE) begin
                rx_data <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_frame.sv
// tb_spi_master_frame: directed bench for spi_master_frame (FRAME_BITS=32,
// CLK_DIV=2) with an expected-rx_data queue and per-frame timing checks.
module tb_spi_master_frame;

    localparam int FB      = 32;
    localparam int CD      = 2;
    localparam int DONE_AT = 1 + CD * (1 + 2 * FB);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [FB-1:0] tx_data;
    wire  [FB-1:0] rx_data;
    wire           busy, done, sck, cs_n, sdo;
    wire           sdi;
    logic          loop_en;
    logic          sdi_val;

    int            vectors = 0;
    int            miscompares = 0;
    logic [FB-1:0] exp_q[$];

    // per-frame observations
    int            rises, low_cnt, last_low, done_n, viol;
    logic          busy_at_done, cs_n_at_done, sck_at_done, sdo_or;
    logic [FB-1:0] sdo_seq;

    assign sdi = loop_en ? sdo : sdi_val;

    spi_master_frame #(.FRAME_BITS(FB), .CLK_DIV(CD)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .sck     (sck),
        .cs_n    (cs_n),
        .sdo     (sdo),
        .sdi     (sdi)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [FB-1:0] bitrev(input logic [FB-1:0] v);
        logic [FB-1:0] r;
        for (int i = 0; i < FB; i++) r[i] = v[FB-1-i];
        return r;
    endfunction

    // order in which tx bits appear on sdo, first bit in the MSB position
    function automatic logic [FB-1:0] exp_sdo(input logic [FB-1:0] tx);
`ifdef SPI_LSB_FIRST_EN
        return bitrev(tx);
`else
        return tx;
`endif
    endfunction

    // Drive one frame; called at a negedge with the DUT idle. The start is
    // accepted on the next posedge (edge k); n counts negedges after it.
    task automatic run_frame(input logic [FB-1:0] tx, input logic hold);
        logic prev_sck;
        start   = 1'b1;
        tx_data = tx;
        exp_q.push_back(loop_en ? tx : {FB{sdi_val}});
        rises = 0; low_cnt = 0; last_low = 0; done_n = 0; viol = 0;
        busy_at_done = 1'bx; cs_n_at_done = 1'bx; sck_at_done = 1'bx;
        sdo_or = 1'b0; sdo_seq = '0; prev_sck = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (!hold) start = 1'b0;
                tx_data = $urandom();
            end
            if (sck && !prev_sck) begin
                rises++;
                sdo_seq = {sdo_seq[FB-2:0], sdo};
            end
            prev_sck = sck;
            if (!cs_n) begin
                low_cnt++;
                last_low = n;
                sdo_or = sdo_or | sdo;
            end
            if (cs_n && sck) viol++;
            if (done) begin
                done_n       = n;
                busy_at_done = busy;
                cs_n_at_done = cs_n;
                sck_at_done  = sck;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [FB-1:0] tx);
        logic [FB-1:0] e;
        chk({tag, "_sck_rises"}, 32'(rises), 32'(FB));
        chk({tag, "_done_cycle"}, 32'(done_n), 32'(DONE_AT));
        chk({tag, "_csn_low_cycles"}, 32'(low_cnt), 32'(DONE_AT - 1));
        chk({tag, "_csn_last_low"}, 32'(last_low), 32'(DONE_AT - 1));
        chk({tag, "_sck_while_csn_high"}, 32'(viol), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        chk({tag, "_csn_at_done"}, 32'(cs_n_at_done), 32'd1);
        chk({tag, "_sck_at_done"}, 32'(sck_at_done), 32'd0);
        chk({tag, "_sdo_seq"}, sdo_seq, exp_sdo(tx));
        if (exp_q.size() == 0) begin
            chk({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rx_data"}, rx_data, e);
        end
    endtask

    initial begin
        logic prev_sck;
        logic done_seen;
        int   r;
        logic [FB-1:0] rtx;

        // reset block
        reset = 1'b1; start = 1'b0; tx_data = '0; loop_en = 1'b0; sdi_val = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_csn", 32'(cs_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_rx", rx_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // loopback frame
        loop_en = 1'b1;
        run_frame(32'hA5A50F3C, 1'b0);
        check_frame("loop_a5", 32'hA5A50F3C);
        @(negedge clk);

        // constant sdi=1, tx all zeros
        loop_en = 1'b0; sdi_val = 1'b1;
        run_frame(32'h00000000, 1'b0);
        check_frame("const1", 32'h00000000);
        chk("const1_sdo_low", 32'(sdo_or), 32'd0);
        @(negedge clk);

        // start held through the frame: no re-accept in DONE, 1-cycle gap
        loop_en = 1'b1;
        run_frame(32'h3C96E10F, 1'b1);
        check_frame("held1", 32'h3C96E10F);
        @(negedge clk);
        chk("held_gap_csn", 32'(cs_n), 32'd1);
        chk("held_gap_busy", 32'(busy), 32'd0);
        run_frame(32'h5AF01234, 1'b0);
        check_frame("held2", 32'h5AF01234);
        @(negedge clk);

        // reset after the 10th sck rise
        start = 1'b1; tx_data = 32'hFFFF0000; r = 0; prev_sck = 1'b0;
        for (int n = 0; n < 200 && r < 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (sck && !prev_sck) r++;
            prev_sck = sck;
        end
        chk("midrst_reached_10", 32'(r), 32'd10);
        reset = 1'b1;
        #1;
        chk("midrst_sck", 32'(sck), 32'd0);
        chk("midrst_csn", 32'(cs_n), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rx", rx_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        run_frame(32'h12345678, 1'b0);
        check_frame("after_rst", 32'h12345678);
        @(negedge clk);

        // a few random loopback frames
        for (int i = 0; i < 3; i++) begin
            rtx = $urandom_range(32'hFFFFFFFF, 0);
            run_frame(rtx, 1'b0);
            check_frame("rand", rtx);
            @(negedge clk);
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
